xdbl_sequencer: RTL and testbench

//  Sequences cryptoprocessor_wrapper_1506 through N successive Montgomery x-only doublings
//  (x,z) <- [2](x,z), the core repeated step of the isogeny VDF evaluation.

---
 rtl/xdbl_sequencer.sv | 158 +++++++++++++++
 tb/tb_xdbl_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdbl_sequencer.sv
// Sequencer that drives the cryptoprocessor wrapper through N Montgomery x-only doublings
// from a 12-entry command ROM, with a start/busy/done handshake to the host.
module xdbl_sequencer #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16,
  parameter int X_A    = 0,
  parameter int Z_A    = 1,
  parameter int A_A    = 2,
  parameter int C_A    = 3,
  parameter int T0_A   = 4,
  parameter int T1_A   = 5,
  parameter int XO_A   = 6,
  parameter int ZO_A   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      n_dbl,
  output logic                  busy,
  output logic                  done,
  input  logic                  cmd_ready,
  input  logic                  dp_idle,
  output logic                  ins_in,
  output logic                  data_en,
  output logic [3+3*ADDR_W-1:0] command_out,
  output logic [2:0]            state_dbg
);

  localparam int CMD_W = 3 + 3 * ADDR_W;
  localparam logic [ADDR_W-1:0] XA  = ADDR_W'(X_A);
  localparam logic [ADDR_W-1:0] ZA  = ADDR_W'(Z_A);
  localparam logic [ADDR_W-1:0] AA  = ADDR_W'(A_A);
  localparam logic [ADDR_W-1:0] CA  = ADDR_W'(C_A);
  localparam logic [ADDR_W-1:0] T0  = ADDR_W'(T0_A);
  localparam logic [ADDR_W-1:0] T1  = ADDR_W'(T1_A);
  localparam logic [ADDR_W-1:0] XO  = ADDR_W'(XO_A);
  localparam logic [ADDR_W-1:0] ZO  = ADDR_W'(ZO_A);
  localparam logic [ADDR_W-1:0] NUL = '0;

  localparam logic [2:0] OP_CPY = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_COPY, S_CDRAIN, S_FINISH
  } state_t;

  state_t           state, state_n;
  logic [3:0]       pc, pc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n, ins_n;
  logic [CMD_W-1:0] cmd_n;

  // Entries 0..9 are one doubling; 10..11 feed the result back into x/z.
  function automatic logic [CMD_W-1:0] rom(input logic [3:0] idx);
    logic [CMD_W-1:0] c;
    case (idx)
      4'd0:    c = {OP_SUB, XA, ZA, T0};
      4'd1:    c = {OP_ADD, XA, ZA, T1};
      4'd2:    c = {OP_MUL, T0, T0, T0};
      4'd3:    c = {OP_MUL, T1, T1, T1};
      4'd4:    c = {OP_MUL, CA, T0, ZO};
      4'd5:    c = {OP_MUL, ZO, T1, XO};
      4'd6:    c = {OP_SUB, T1, T0, T1};
      4'd7:    c = {OP_MUL, AA, T1, T0};
      4'd8:    c = {OP_ADD, ZO, T0, ZO};
      4'd9:    c = {OP_MUL, ZO, T1, ZO};
      4'd10:   c = {OP_CPY, XO, NUL, XA};
      4'd11:   c = {OP_CPY, ZO, NUL, ZA};
      default: c = '0;
    endcase
    return c;
  endfunction

  // Handshake: a command transfers on every rising edge where ins_in && cmd_ready;
  // while cmd_ready is low, ins_in and command_out hold their values.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (n_dbl != '0) begin
            cnt_n   = n_dbl;
            pc_n    = 4'd0;
            state_n = S_ISSUE;
          end else begin
            state_n = S_FINISH;
          end
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          if (pc == 4'd9) state_n = S_DRAIN;
          else            pc_n    = pc + 4'd1;
        end
      end
      S_DRAIN: begin
        if (dp_idle) begin
          if (cnt == CNT_W'(1)) begin
            state_n = S_FINISH;
          end else begin
            pc_n    = 4'd10;
            state_n = S_COPY;
          end
        end
      end
      S_COPY: begin
        if (cmd_ready) begin
          if (pc == 4'd11) begin
            cnt_n   = cnt - CNT_W'(1);
            pc_n    = 4'd0;
            state_n = S_CDRAIN;
          end else begin
            pc_n = pc + 4'd1;
          end
        end
      end
      S_CDRAIN: begin
        if (dp_idle) state_n = S_ISSUE;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    // Outputs are precomputed from the next state so they leave flops.
    ins_n  = (state_n == S_ISSUE) || (state_n == S_COPY);
    cmd_n  = ins_n ? rom(pc_n) : '0;
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= 4'd0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ins_in      <= 1'b0;
      command_out <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      ins_in      <= ins_n;
      command_out <= cmd_n;
    end
  end

  assign data_en   = 1'b0;
  assign state_dbg = state;

endmodule

// File: tb/tb_xdbl_sequencer.sv
// Bench for xdbl_sequencer: emulates the wrapper register file with arithmetic mod a small
// prime and checks the command stream, timing and results against the doubling formulas.
module tb_xdbl_sequencer;

  localparam int AW = 7;
  localparam int CW = 16;
  localparam int DW = 3 + 3 * AW;
  localparam logic [63:0] P = 64'd4294967291;

  logic          clk = 1'b0;
  logic          rst, start, cmd_ready, dp_idle;
  logic [CW-1:0] n_dbl;
  logic          busy, done, ins_in, data_en;
  logic [DW-1:0] command_out;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  xdbl_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .n_dbl(n_dbl), .busy(busy), .done(done),
    .cmd_ready(cmd_ready), .dp_idle(dp_idle), .ins_in(ins_in), .data_en(data_en),
    .command_out(command_out), .state_dbg(state_dbg)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [63:0]   rf[0:127];
  logic [63:0]   x0, z0, a0, c0;
  bit            rand_ready = 1'b0;
  int            stall_viol = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_cmd = '0;
  int            lat;
  bit            busy_at_done;

  // ---------------- arithmetic mod P ----------------
  function automatic logic [63:0] mm(input logic [63:0] a, input logic [63:0] b);
    return (a * b) % P;
  endfunction
  function automatic logic [63:0] ma(input logic [63:0] a, input logic [63:0] b);
    return (a + b) % P;
  endfunction
  function automatic logic [63:0] ms(input logic [63:0] a, input logic [63:0] b);
    return (a + P - b) % P;
  endfunction

  // Closed-form x-only doubling: X=c(x-z)^2(x+z)^2, Z=4xz(c(x-z)^2 + a*4xz)
  task automatic model(input int n, output logic [63:0] xe, output logic [63:0] ze);
    logic [63:0] x, z, s2, t2, e;
    x = x0; z = z0;
    for (int i = 0; i < n; i++) begin
      s2 = mm(ms(x, z), ms(x, z));
      t2 = mm(ma(x, z), ma(x, z));
      e  = ms(t2, s2);
      x  = mm(c0, mm(s2, t2));
      z  = mm(e, ma(mm(c0, s2), mm(a0, e)));
    end
    xe = x; ze = z;
  endtask

  // ---------------- expected command stream ----------------
  function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic [6:0] r1,
                                        input logic [6:0] r2, input logic [6:0] w);
    return {op, r1, r2, w};
  endfunction

  function automatic logic [DW-1:0] rom_cmd(input int i);
    case (i)
      0:  return enc(3'd4, 7'd0, 7'd1, 7'd4);
      1:  return enc(3'd3, 7'd0, 7'd1, 7'd5);
      2:  return enc(3'd5, 7'd4, 7'd4, 7'd4);
      3:  return enc(3'd5, 7'd5, 7'd5, 7'd5);
      4:  return enc(3'd5, 7'd3, 7'd4, 7'd7);
      5:  return enc(3'd5, 7'd7, 7'd5, 7'd6);
      6:  return enc(3'd4, 7'd5, 7'd4, 7'd5);
      7:  return enc(3'd5, 7'd2, 7'd5, 7'd4);
      8:  return enc(3'd3, 7'd7, 7'd4, 7'd7);
      9:  return enc(3'd5, 7'd7, 7'd5, 7'd7);
      10: return enc(3'd2, 7'd6, 7'd0, 7'd0);
      11: return enc(3'd2, 7'd7, 7'd0, 7'd1);
      default: return '0;
    endcase
  endfunction

  task automatic build_exp(input int n);
    exp_q.delete();
    for (int it = 0; it < n; it++) begin
      for (int k = 0; k < 10; k++) exp_q.push_back(rom_cmd(k));
      if (it < n - 1) begin
        exp_q.push_back(rom_cmd(10));
        exp_q.push_back(rom_cmd(11));
      end
    end
  endtask

  // ---------------- datapath emulation + monitor ----------------
  task automatic exec(input logic [DW-1:0] c);
    logic [2:0] op;
    logic [6:0] r1, r2, w;
    {op, r1, r2, w} = c;
    case (op)
      3'd2: rf[w] = rf[r1];
      3'd3: rf[w] = ma(rf[r1], rf[r2]);
      3'd4: rf[w] = ms(rf[r1], rf[r2]);
      3'd5: rf[w] = mm(rf[r1], rf[r2]);
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (ins_in !== 1'b1 || command_out !== prev_cmd)) stall_viol++;
      if (ins_in && cmd_ready) begin
        got_q.push_back(command_out);
        exec(command_out);
      end
      prev_stall = ins_in && !cmd_ready;
      prev_cmd   = command_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_operands();
    for (int i = 0; i < 128; i++) rf[i] = '0;
    x0 = 64'($urandom) % P; z0 = 64'($urandom) % P;
    a0 = 64'($urandom) % P; c0 = 64'($urandom) % P;
    rf[0] = x0; rf[1] = z0; rf[2] = a0; rf[3] = c0;
  endtask

  // Pulses start with n and counts cycles until done; release_at raises dp_idle,
  // poke_start pulses start again mid-run with a different count.
  task automatic run_seq(input int n, input int release_at, input bit poke_start);
    bit seen;
    got_q.delete();
    build_exp(n);
    @(posedge clk); #1; start = 1'b1; n_dbl = CW'(n);
    @(posedge clk); #1; start = 1'b0;
    lat = 0; seen = 1'b0; busy_at_done = 1'b0;
    while (!seen && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (lat == release_at) dp_idle = 1'b1;
      if (poke_start && lat == 4) begin start = 1'b1; n_dbl = CW'(5); end
      if (poke_start && lat == 5) start = 1'b0;
      if (done) begin seen = 1'b1; busy_at_done = busy; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout n=%0d waited %0d cycles", n, lat); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL post_done busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic scoreboard(input string name, input int n, input bit check_res);
    logic [DW-1:0] e, g;
    logic [63:0] xe, ze;
    int idx = 0;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s cmd_count got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL %s cmd[%0d] got %h required %h", name, idx, g, e);
      end
      idx++;
    end
    if (check_res) begin
      model(n, xe, ze);
      checks++;
      if (rf[6] !== xe) begin errors++; $display("FAIL %s x_dbl got %h required %h", name, rf[6], xe); end
      checks++;
      if (rf[7] !== ze) begin errors++; $display("FAIL %s z_dbl got %h required %h", name, rf[7], ze); end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, ins_in, data_en} !== 4'b0000 || command_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got b/d/i/e=%b%b%b%b cmd=%h required 0000/0",
               busy, done, ins_in, data_en, command_out);
    end
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ins_in !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b ins_in=%b required 0/0", busy, ins_in);
    end
  endtask

  task automatic test_single();
    load_operands();
    run_seq(1, 0, 1'b0);
    checks++;
    if (lat != 12) begin errors++; $display("FAIL single_latency got %0d required 12", lat); end
    checks++;
    if (busy_at_done !== 1'b1) begin errors++; $display("FAIL single_busy_at_done got %b required 1", busy_at_done); end
    checks++;
    if (data_en !== 1'b0) begin errors++; $display("FAIL data_en got %b required 0", data_en); end
    scoreboard("single", 1, 1'b1);
  endtask

  task automatic test_chain();
    load_operands();
    run_seq(3, 0, 1'b0);
    checks++;
    if (lat != 14 * 2 + 12) begin errors++; $display("FAIL chain_latency got %0d required %0d", lat, 40); end
    scoreboard("chain3", 3, 1'b1);
  endtask

  task automatic test_stall();
    load_operands();
    stall_viol = 0;
    rand_ready = 1'b1;
    run_seq(2, 0, 1'b0);
    rand_ready = 1'b0;
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL stall_stability got %0d changes required 0", stall_viol); end
    scoreboard("stall", 2, 1'b1);
  endtask

  task automatic test_drain_hold();
    load_operands();
    dp_idle = 1'b0;
    run_seq(1, 31, 1'b0);
    dp_idle = 1'b1;
    checks++;
    if (lat != 32) begin errors++; $display("FAIL drain_hold_latency got %0d required 32", lat); end
    scoreboard("drain_hold", 1, 1'b1);
  endtask

  task automatic test_zero_and_busy_start();
    load_operands();
    run_seq(0, 0, 1'b0);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL zero_latency got %0d required 1", lat); end
    checks++;
    if (busy_at_done !== 1'b1) begin errors++; $display("FAIL zero_busy got %b required 1", busy_at_done); end
    scoreboard("zero", 0, 1'b0);
    load_operands();
    run_seq(1, 0, 1'b1);
    checks++;
    if (lat != 12) begin errors++; $display("FAIL busy_start_latency got %0d required 12", lat); end
    scoreboard("busy_start", 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    load_operands();
    got_q.delete();
    @(posedge clk); #1; start = 1'b1; n_dbl = CW'(3);
    @(posedge clk); #1; start = 1'b0;
    while (got_q.size() < 17 && guard < 500) begin @(negedge clk); #1; guard++; end
    checks++;
    if (got_q.size() < 17) begin errors++; $display("FAIL reset_mid_timeout got %0d cmds required 17", got_q.size()); end
    @(negedge clk); #1;
    checks++;
    if (ins_in !== 1'b1 || command_out !== rom_cmd(5)) begin
      errors++; $display("FAIL reset_mid_pc5 got %b/%h required 1/%h", ins_in, command_out, rom_cmd(5));
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, ins_in} !== 3'b000 || command_out !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got b/d/i=%b%b%b cmd=%h required 000/0",
                         busy, done, ins_in, command_out);
    end
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    load_operands();
    run_seq(1, 0, 1'b0);
    checks++;
    if (lat != 12) begin errors++; $display("FAIL after_reset_latency got %0d required 12", lat); end
    scoreboard("after_reset", 1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_dbl = '0; cmd_ready = 1'b1; dp_idle = 1'b1;
    test_reset();
    test_single();
    test_chain();
    test_stall();
    test_drain_hold();
    test_zero_and_busy_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
